clkbuf_src_divider: RTL and testbench
=====================================

// Module: clkbuf_src_divider
// PURPOSE
//  Programmable integer clock divider that generates the source clock driven
//  into a clkbuf cell. Output Z is a flop output, so it is glitch-free.
//  Ratio changes and start/stop take effect only on period boundaries, so the
//  downstream buffer never sees a runt pulse.
//  Clock-generation logic; sits directly upstream of the clkbuf cell input I.
// PARAMETERS
//  WIDTH  8  width of the DIV request and of the internal period counter
// PORTS
//  CLK      input   1      source clock; all state updates on the rising edge
//  RST      input   1      synchronous, active-high reset
//  EN       input   1      run request; 1 = produce clock, 0 = stop at period end
//  DIV      input   WIDTH  requested ratio N; values 0 and 1 are clamped to 2
//  DIV_VLD  input   1      DIV request valid
//  DIV_RDY  output  1      request slot free; DIV_RDY = ~pend_vld (register-derived)
//  Z        output  1      divided clock, registered; drives clkbuf input I
//  ACTIVE   output  1      1 while the state is RUN
//  VDD      inout   1      power pin, no logic function
//  VSS      inout   1      ground pin, no logic function
// BEHAVIOUR
//  State: st{OFF,RUN}, cnt[WIDTH], ratio_cur[WIDTH], ratio_pend[WIDTH], pend_vld, Z.
//  Reset (RST=1 at an edge), regardless of state:
//   st=OFF, cnt=0, ratio_cur=2, pend_vld=0, Z=0.
//   Outputs next cycle: DIV_RDY=1, ACTIVE=0. Any pending request is discarded.
//  Accept: DIV_VLD & DIV_RDY at an edge -> ratio_pend = (DIV<2 ? 2 : DIV), pend_vld=1.
//   DIV_VLD with DIV_RDY=0 is not accepted; the requester holds DIV_VLD and DIV.
//  Boundary: the OFF->RUN start edge, or an edge in RUN with cnt==ratio_cur-1.
//   At a boundary, if pend_vld was already 1 before that edge:
//   ratio_cur=ratio_pend, pend_vld=0.
//   A request accepted on a boundary edge is applied at the next boundary.
//  High phase: H = ratio_cur>>1, using the ratio in force for the new period.
//   Z=1 for cnt<H, else 0. N=5 gives 2 cycles high, 3 low.
//  OFF: Z=0.
//   EN=1 at an edge -> st=RUN, cnt=0, Z=1 (Z rises 1 cycle after EN is sampled).
//   EN=0 -> no change.
//  RUN, cnt!=ratio_cur-1: cnt=cnt+1, Z=(cnt+1<H).
//   EN is ignored mid-period; a stop request never truncates a period.
//  RUN, cnt==ratio_cur-1:
//   EN=1 -> cnt=0, Z=1, apply pending.
//   EN=0 -> st=OFF, cnt=0, Z=0. Pending is kept and applied at the next start.
//  Widths: the maximum ratio is 2^WIDTH-1. cnt never exceeds ratio_cur-1, so no overflow.
//  Simultaneous RST and any other event: RST wins.
// TESTING
//  T1: reset, EN=1 held, no DIV -> Z from the cycle after EN: 1,0,1,0...; ACTIVE=1.
//  T2: running N=2, accept DIV=5 -> next boundary starts period 1,1,0,0,0 repeating;
//      DIV_RDY low until applied.
//  T3: DIV=0, then DIV=1 -> each is applied as N=2 (Z toggles every cycle).
//  T4: DIV=4 accepted; DIV=6 offered next cycle -> held (DIV_RDY=0) until 4 applies;
//      6 takes effect one period later.
//  T5: N=4, EN drops at cnt=1 -> Z completes 1,1,0,0 then stays 0, ACTIVE=0;
//      EN=1 again -> Z=1 next cycle.
//  T6: RST at cnt=2 of N=6 with a request pending -> next cycle Z=0, ACTIVE=0,
//      DIV_RDY=1; restart runs at N=2.

Source files
------------

// File: rtl/clkbuf_src_divider.sv
// Programmable integer clock divider feeding a clkbuf input. Ratio changes and
// start/stop only take effect on period boundaries, so Z never produces a runt pulse.
module clkbuf_src_divider #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             DIV_VLD,
    output logic             DIV_RDY,
    output logic             Z,
    output logic             ACTIVE,
    inout  wire              VDD,
    inout  wire              VSS
);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] RATIO_MIN = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           r_st;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_ratio_cur;
    logic [WIDTH-1:0] r_ratio_pend;
    logic             r_pend_vld;
    logic             r_z;

    logic             w_last;
    logic             w_start;
    logic             w_apply;
    logic             w_accept;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_div_clamped;
    logic             w_unused_pwr;

    // Power pins carry no logic; fold them into a sink so they are referenced.
    assign w_unused_pwr  = VDD ^ VSS;

    assign w_last        = (r_cnt == (r_ratio_cur - ONE));
    assign w_cnt_inc     = r_cnt + ONE;
    // A new period begins on the OFF->RUN edge or on a wrap with EN still high.
    assign w_start       = EN & ((r_st == ST_OFF) | ((r_st == ST_RUN) & w_last));
    assign w_apply       = w_start & r_pend_vld;
    assign w_accept      = DIV_VLD & ~r_pend_vld;
    assign w_div_clamped = (DIV < RATIO_MIN) ? RATIO_MIN : DIV;

    assign DIV_RDY = ~r_pend_vld;
    assign ACTIVE  = (r_st == ST_RUN);
    assign Z       = r_z;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_st         <= ST_OFF;
            r_cnt        <= '0;
            r_ratio_cur  <= RATIO_MIN;
            r_ratio_pend <= RATIO_MIN;
            r_pend_vld   <= 1'b0;
            r_z          <= 1'b0;
        end else begin
            // accept and apply are exclusive: one needs pend_vld low, the other high
            if (w_accept) begin
                r_ratio_pend <= w_div_clamped;
                r_pend_vld   <= 1'b1;
            end
            if (w_apply) begin
                r_ratio_cur <= r_ratio_pend;
                r_pend_vld  <= 1'b0;
            end

            case (r_st)
                ST_OFF: begin
                    r_z <= 1'b0;
                    if (EN) begin
                        r_st  <= ST_RUN;
                        r_cnt <= '0;
                        r_z   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_last) begin
                        r_cnt <= w_cnt_inc;
                        r_z   <= (w_cnt_inc < (r_ratio_cur >> 1));
                    end else if (EN) begin
                        r_cnt <= '0;
                        r_z   <= 1'b1;
                    end else begin
                        r_st  <= ST_OFF;
                        r_cnt <= '0;
                        r_z   <= 1'b0;
                    end
                end
                default: begin
                    r_st  <= ST_OFF;
                    r_cnt <= '0;
                    r_z   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkbuf_src_divider.sv
// Bench for clkbuf_src_divider: a vector table plus hand-built sequences, all
// checked through an expected queue of {Z, ACTIVE, DIV_RDY} per clock.
module tb_clkbuf_src_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] div;
  logic         div_vld;
  logic         div_rdy;
  logic         z;
  logic         active;
  wire          vdd;
  wire          vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  clkbuf_src_divider #(.WIDTH(W)) dut (
    .CLK     (clk),
    .RST     (rst),
    .EN      (en),
    .DIV     (div),
    .DIV_VLD (div_vld),
    .DIV_RDY (div_rdy),
    .Z       (z),
    .ACTIVE  (active),
    .VDD     (vdd),
    .VSS     (vss)
  );

  // expected {Z, ACTIVE, DIV_RDY} after each clock edge
  logic [2:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         rst;
    logic         en;
    logic         vld;
    logic [W-1:0] div;
    logic [2:0]   exp;
  } vec_t;

  vec_t tbl[10];

  task automatic push(input logic ez, input logic ea, input logic er);
    exp_q.push_back({ez, ea, er});
  endtask

  // one full period of ratio n: n>>1 cycles high, rest low, running, slot free
  task automatic push_period(input int n);
    for (int i = 0; i < n; i++) push((i < (n >> 1)) ? 1'b1 : 1'b0, 1'b1, 1'b1);
  endtask

  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [W-1:0] d, input string tag);
    logic [2:0] ex;
    rst = r; en = e; div_vld = v; div = d;
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got z/act/rdy=%b, required value missing from queue",
               tag, {z, active, div_rdy});
    end else begin
      ex = exp_q.pop_front();
      if ({z, active, div_rdy} !== ex) begin
        n_fail++;
        $display("FAIL %s @%0t: got z/act/rdy=%b, required %b",
                 tag, $time, {z, active, div_rdy}, ex);
      end
    end
  endtask

  task automatic drive_n(input logic e, input int n, input string tag);
    for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, '0, tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = '0; div_vld = 1'b0;

    // reset, start at N=2, then DIV=0 and DIV=1 each clamp to 2
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 3'b001};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'b111};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'b011};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'b111};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'd0, 3'b010};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'b111};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'd1, 3'b010};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'b111};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'b011};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'b111};

    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(tbl[i].exp);
      drive(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].div, $sformatf("tbl[%0d]", i));
    end

    // DIV=5 accepted on a boundary edge waits a full period before applying
    push(0, 0, 1);
    push(1, 1, 1); push(0, 1, 1); push(1, 1, 0); push(0, 1, 0);
    push_period(5); push_period(5);
    drive(1'b1, 1'b0, 1'b0, '0, "t2_rst");
    drive_n(1'b1, 2, "t2_n2");
    drive(1'b0, 1'b1, 1'b1, 8'd5, "t2_req5");
    drive_n(1'b1, 11, "t2_n5");

    // DIV=4 pending, DIV=6 held off until 4 applies, then 6 one period later
    push(0, 0, 1);
    push(1, 1, 1); push(0, 1, 0); push(1, 1, 1); push(1, 1, 0);
    push(0, 1, 0); push(0, 1, 0);
    push_period(6);
    drive(1'b1, 1'b0, 1'b0, '0, "t4_rst");
    drive(1'b0, 1'b1, 1'b0, '0, "t4_start");
    drive(1'b0, 1'b1, 1'b1, 8'd4, "t4_req4");
    drive(1'b0, 1'b1, 1'b1, 8'd6, "t4_hold6");
    drive(1'b0, 1'b1, 1'b1, 8'd6, "t4_req6");
    drive_n(1'b1, 8, "t4_run");

    // N=4, EN drops at cnt=1: period completes, then OFF, then restart
    push(0, 0, 1);
    push(1, 1, 0); push(0, 1, 0); push(1, 1, 1); push(1, 1, 1);
    push(0, 1, 1); push(0, 1, 1); push(0, 0, 1); push(0, 0, 1);
    push(1, 1, 1); push(1, 1, 1); push(0, 1, 1);
    drive(1'b1, 1'b0, 1'b0, '0, "t5_rst");
    drive(1'b0, 1'b1, 1'b1, 8'd4, "t5_req4");
    drive_n(1'b1, 3, "t5_run");
    drive_n(1'b0, 4, "t5_stop");
    drive_n(1'b1, 3, "t5_restart");

    // reset mid-period at N=6 with a request pending discards it; restart at N=2
    push(0, 0, 1);
    push(1, 1, 0); push(0, 1, 0); push(1, 1, 1); push(1, 1, 0); push(1, 1, 0);
    push(0, 0, 1);
    push(1, 1, 1); push(0, 1, 1); push(1, 1, 1); push(0, 1, 1);
    drive(1'b1, 1'b0, 1'b0, '0, "t6_rst");
    drive(1'b0, 1'b1, 1'b1, 8'd6, "t6_req6");
    drive_n(1'b1, 2, "t6_run");
    drive(1'b0, 1'b1, 1'b1, 8'd3, "t6_req3");
    drive_n(1'b1, 1, "t6_cnt2");
    drive(1'b1, 1'b1, 1'b0, '0, "t6_midrst");
    drive_n(1'b1, 4, "t6_n2");

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
